// File: rtl/ex_issue_if.sv
// Bus between decode, the execute-issue stage and the ALU/shift units.
// The slave modport is the issue stage's view of the bus. The master modport is the view
// of whatever drives decode beats and consumes issued beats.
interface ex_issue_if #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5,
    parameter int ADDR_W  = 5
);
    // Pipeline kill and the decode-side handshake
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [6:0]         ctrl_in;
    logic [DATA_W-1:0]  src1;
    logic [DATA_W-1:0]  src2;
    logic [DATA_W-1:0]  imm;
    logic [ADDR_W-1:0]  rs1_addr;
    logic [ADDR_W-1:0]  rs2_addr;
    logic [DATA_W-1:0]  mem_rdata;

    // Write-back snoop; only used when forwarding is built in
    logic               wb_we;
    logic [ADDR_W-1:0]  wb_addr;
    logic [DATA_W-1:0]  wb_data;

    // Store port to data memory
    logic               mem_wr_en;
    logic [DATA_W-1:0]  mem_wr_data;

    // Issue-side handshake and operands
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  aluin1;
    logic [DATA_W-1:0]  aluin2;
    logic [2:0]         operation_out;
    logic [2:0]         opselect_out;
    logic               enable_arith;
    logic               enable_shift;
    logic [SHAMT_W-1:0] shift_number;
    logic               illegal_op;

    modport slave (
        input  flush, in_valid, ctrl_in, src1, src2, imm, rs1_addr, rs2_addr, mem_rdata,
        input  wb_we, wb_addr, wb_data, out_ready,
        output in_ready, mem_wr_en, mem_wr_data, out_valid, aluin1, aluin2,
        output operation_out, opselect_out, enable_arith, enable_shift, shift_number,
        output illegal_op
    );

    modport master (
        output flush, in_valid, ctrl_in, src1, src2, imm, rs1_addr, rs2_addr, mem_rdata,
        output wb_we, wb_addr, wb_data, out_ready,
        input  in_ready, mem_wr_en, mem_wr_data, out_valid, aluin1, aluin2,
        input  operation_out, opselect_out, enable_arith, enable_shift, shift_number,
        input  illegal_op
    );
endinterface

// File: rtl/ex_issue_stage.sv
// Execute-issue stage. It decodes the 7-bit control word, selects the ALU operands and
// the shift amount, and issues stores straight to data memory. Enqueued beats go into an
// output register (O) backed by a skid register (S). This keeps throughput at one beat
// per cycle under backpressure.
// Optional build macro: EX_FWD_EN adds write-back forwarding onto src1/src2.
module ex_issue_stage #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5,
    parameter int ADDR_W  = 5
) (
    input logic       clk,
    input logic       reset,
    ex_issue_if.slave bus
);

    localparam logic [2:0] OP_SHIFT = 3'd0;
    localparam logic [2:0] OP_ARITH = 3'd1;
    localparam logic [2:0] OP_STORE = 3'd4;
    localparam logic [2:0] OP_LOAD  = 3'd5;

    typedef struct packed {
        logic [DATA_W-1:0]  a1;
        logic [DATA_W-1:0]  a2;
        logic [2:0]         operation;
        logic [2:0]         opselect;
        logic               en_arith;
        logic               en_shift;
        logic [SHAMT_W-1:0] shamt;
    } beat_t;

    logic [DATA_W-1:0] src1_eff;
    logic [DATA_W-1:0] src2_eff;

`ifdef EX_FWD_EN
    logic fwd1;
    logic fwd2;

    // Bypass a same-cycle write-back onto either source; register 0 is never forwarded
    always_comb begin
        fwd1     = bus.wb_we && (bus.wb_addr == bus.rs1_addr) && (bus.wb_addr != '0);
        fwd2     = bus.wb_we && (bus.wb_addr == bus.rs2_addr) && (bus.wb_addr != '0);
        src1_eff = fwd1 ? bus.wb_data : bus.src1;
        src2_eff = fwd2 ? bus.wb_data : bus.src2;
    end
`else
    logic unused_fwd;
    assign src1_eff   = bus.src1;
    assign src2_eff   = bus.src2;
    assign unused_fwd = ^{bus.rs1_addr, bus.rs2_addr, bus.wb_we, bus.wb_addr, bus.wb_data};
`endif

    logic [2:0] opsel;
    logic       flag;
    logic       is_enq;
    logic       is_store;
    logic       is_illegal;
    beat_t      beat_new;

    assign opsel = bus.ctrl_in[2:0];
    assign flag  = bus.ctrl_in[3];

    // Decode the control word into an issue class and the beat that would be enqueued
    always_comb begin
        is_enq             = 1'b0;
        is_store           = 1'b0;
        is_illegal         = 1'b0;
        beat_new           = '0;
        beat_new.a1        = src1_eff;
        beat_new.operation = bus.ctrl_in[6:4];
        beat_new.opselect  = opsel;
        case (opsel)
            OP_SHIFT: begin
                is_enq            = 1'b1;
                beat_new.a2       = src2_eff;
                beat_new.en_shift = 1'b1;
                beat_new.shamt    = bus.imm[2] ? src2_eff[SHAMT_W-1:0] : bus.imm[6 +: SHAMT_W];
            end
            OP_ARITH: begin
                is_enq            = 1'b1;
                beat_new.a2       = flag ? bus.imm : src2_eff;
                beat_new.en_arith = 1'b1;
            end
            OP_STORE: begin
                if (flag) begin
                    is_store = 1'b1;
                end else begin
                    is_illegal = 1'b1;
                end
            end
            OP_LOAD: begin
                // With the flag clear this code is a nop: it is consumed without effect
                if (flag) begin
                    is_enq            = 1'b1;
                    beat_new.a2       = bus.mem_rdata;
                    beat_new.en_arith = 1'b1;
                end
            end
            default: is_illegal = 1'b1;
        endcase
    end

    logic  o_vld_q, o_vld_d;
    logic  s_vld_q, s_vld_d;
    beat_t o_beat_q, o_beat_d;
    beat_t s_beat_q, s_beat_d;
    logic  illegal_q, illegal_d;
    logic  accept;
    logic  enq;
    logic  o_free;

    assign bus.in_ready = !s_vld_q;
    assign accept       = bus.in_valid && !s_vld_q && !bus.flush;
    assign enq          = accept && is_enq;
    assign o_free       = !o_vld_q || bus.out_ready;

    // O/S occupancy: refill O from S first, otherwise from the new beat; park in S when O stalls
    always_comb begin
        o_vld_d   = o_vld_q;
        s_vld_d   = s_vld_q;
        o_beat_d  = o_beat_q;
        s_beat_d  = s_beat_q;
        illegal_d = accept && is_illegal;
        if (bus.flush) begin
            o_vld_d = 1'b0;
            s_vld_d = 1'b0;
        end else if (o_free) begin
            if (s_vld_q) begin
                o_beat_d = s_beat_q;
                o_vld_d  = 1'b1;
                s_vld_d  = 1'b0;
            end else if (enq) begin
                o_beat_d = beat_new;
                o_vld_d  = 1'b1;
            end else begin
                o_vld_d = 1'b0;
            end
        end else if (enq) begin
            s_beat_d = beat_new;
            s_vld_d  = 1'b1;
        end
    end

    // Control state: reset clears the valids and the illegal-op pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            o_vld_q   <= 1'b0;
            s_vld_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            o_vld_q   <= o_vld_d;
            s_vld_q   <= s_vld_d;
            illegal_q <= illegal_d;
        end
    end

    // Payload registers: no reset needed because every output is gated by out_valid
    always_ff @(posedge clk) begin
        o_beat_q <= o_beat_d;
        s_beat_q <= s_beat_d;
    end

    beat_t beat_out;
    assign beat_out = o_vld_q ? o_beat_q : '0;

    assign bus.out_valid     = o_vld_q;
    assign bus.aluin1        = beat_out.a1;
    assign bus.aluin2        = beat_out.a2;
    assign bus.operation_out = beat_out.operation;
    assign bus.opselect_out  = beat_out.opselect;
    assign bus.enable_arith  = beat_out.en_arith;
    assign bus.enable_shift  = beat_out.en_shift;
    assign bus.shift_number  = beat_out.shamt;
    assign bus.illegal_op    = illegal_q;
    assign bus.mem_wr_en     = accept && is_store;
    assign bus.mem_wr_data   = src2_eff;

endmodule

// File: doc/ex_issue_stage.md
Name: ex_issue_stage

Overview:
Parametrised execute-issue stage that sits between decode and the arithmetic/shift units. It decodes the 7-bit control word, selects ALU operands (register, immediate or memory read data) and the shift amount, and issues stores directly to data memory. Compared with the single-register issue stage, it adds configurable width, a valid/ready handshake with a 2-entry skid buffer (full throughput under backpressure), flush, illegal-op detection and optional write-back forwarding.

Parameters:
DATA_W, 32, datapath width of src1/src2/imm/mem data/ALU operands
SHAMT_W, 5, shift-amount width; must equal clog2(DATA_W)
ADDR_W, 5, register-address width (forwarding compare)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high; sampled on posedge clk only
flush  in  1  synchronous pipeline kill
in_valid  in  1  decode beat valid
in_ready  out  1  stage can accept; equals !skid_valid
ctrl_in  in  7  [2:0] opselect, [3] imm/mem flag, [6:4] operation
src1, src2  in  DATA_W each  register operands
imm  in  DATA_W  immediate
rs1_addr, rs2_addr  in  ADDR_W each  source register numbers (forwarding only)
mem_rdata  in  DATA_W  data-memory read data for loads
wb_we  in  1  write-back valid (forwarding only)
wb_addr  in  ADDR_W  write-back register (forwarding only)
wb_data  in  DATA_W  write-back value (forwarding only)
mem_wr_en  out  1  store strobe, combinational
mem_wr_data  out  DATA_W  store data = effective src2, combinational
out_valid  out  1  issued beat valid
out_ready  in  1  downstream accepts
aluin1, aluin2  out  DATA_W each  ALU operands
operation_out  out  3  ctrl_in[6:4] of issued beat
opselect_out  out  3  ctrl_in[2:0] of issued beat
enable_arith, enable_shift  out  1 each  unit enables, valid-qualified
shift_number  out  SHAMT_W  shift amount
illegal_op  out  1  one-cycle pulse, registered

Behaviour:
- Accept = in_valid && in_ready && !flush. Decode classes (op = ctrl_in[2:0], f = ctrl_in[3]):
  shift: op=0. aluin2 = src2. shift_number = imm[2]?src2[SHAMT_W-1:0]:imm[6+:SHAMT_W]. enable_shift=1.
  arith: op=1. aluin2 = f?imm:src2. enable_arith=1.
  load: op=5, f=1. aluin2 = mem_rdata. enable_arith=1.
  store: op=4, f=1. Not enqueued. mem_wr_en=1 combinationally in the accept cycle.
  nop: op=5, f=0. Consumed, not enqueued, no flag.
  other codes: consumed, not enqueued; illegal_op=1 on the next cycle.
- aluin1 = src1 for all enqueued classes. For non-shift beats shift_number=0. Unused enable=0.
- Storage: output register (O) plus skid register (S). An enqueued beat goes to O if O is empty or out_ready=1 this cycle; otherwise it goes to S. When O drains and S is valid, S moves to O that cycle. in_ready = !S.valid. Latency accept->out_valid is 1 cycle.
- While out_valid=0: enable_arith, enable_shift, shift_number, aluin1, aluin2, operation_out and opselect_out all read 0. Outputs are gated, not just held.
- Data is held stable while out_valid && !out_ready.
- flush: the next cycle O.valid=S.valid=0. The beat presented in the flush cycle is dropped, mem_wr_en is forced 0, and no illegal_op pulse is produced.
- reset (sync): O/S valid=0, all registered outputs 0, illegal_op=0. After reset in_ready=1. reset overrides flush and accept.
- mem_wr_data = effective src2 at all times; it is only meaningful when mem_wr_en=1.

Optional Feature:
EX_FWD_EN defined: if wb_we && wb_addr==rs1_addr && wb_addr!=0, the effective src1 is wb_data; the same rule with rs2_addr gives the effective src2. Applies to aluin1/aluin2, the shift source and mem_wr_data.
EX_FWD_EN undefined: rs*_addr and wb_* inputs are ignored; src1/src2 are used directly.

Test Plan:
- Reset mid-stream: O and S full, reset=1 for 1 cycle -> next cycle out_valid=0, in_ready=1, all outputs 0.
- Arith imm: ctrl_in=7'b010_1_001, src1=5, imm=7, out_ready=1 -> next cycle out_valid=1, aluin1=5, aluin2=7, operation_out=2, enable_arith=1.
- Shift: op=0, imm=32'h0000_0104 (imm[2]=1), src2=32'h23 -> shift_number=3, enable_shift=1. With imm=32'h0000_0140 (imm[2]=0) -> shift_number=5.
- Backpressure: out_ready=0, three back-to-back arith beats A,B,C -> A in O, B in S, in_ready=0 so C is stalled. Raise out_ready -> A,B,C delivered in order, no loss or duplication.
- Store/illegal/flush: store ctrl_in=7'b000_1_100, src2=32'hDEAD_BEEF -> mem_wr_en=1 same cycle, mem_wr_data=DEAD_BEEF, out_valid stays 0. op=3 -> illegal_op=1 one cycle later. Store presented with flush=1 -> mem_wr_en=0.
- EX_FWD_EN: wb_we=1, wb_addr=rs1_addr=4, wb_data=99, src1=1 -> aluin1=99. With wb_addr=0 -> aluin1=1.
